// File: rtl/return_stack.sv
// Hardware return-address stack: DEPTH entries of AW bits, zero-latency top-of-stack read,
// saturating pointer with sticky overflow/underflow flags.
module return_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 10
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [AW-1:0]            pc_in,
    output logic [AW-1:0]            ret_addr,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     ovf,
    output logic                     unf
);

    localparam int PW = $clog2(DEPTH) + 1;

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] sp;
    logic [PW-2:0] wr_idx;
    logic [PW-2:0] top_idx;

    logic do_replace;
    logic do_push;
    logic do_pop;
    logic push_ovf;
    logic pop_unf;

    // Index arithmetic wraps in PW-1 bits, so sp == DEPTH maps its top to DEPTH-1.
    assign wr_idx  = sp[PW-2:0];
    assign top_idx = sp[PW-2:0] - (PW-1)'(1);

    assign empty = (sp == '0);
    assign full  = (sp == PW'(DEPTH));
    assign count = sp;

    assign ret_addr = empty ? '0 : mem[top_idx];

    // A simultaneous push/pop on an empty stack degenerates to a plain push.
    assign do_replace = push & pop & ~empty;
    assign do_push    = push & (~pop | empty) & ~full;
    assign push_ovf   = push & ~pop & full;
    assign do_pop     = pop & ~push & ~empty;
    assign pop_unf    = pop & ~push & empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp  <= '0;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (do_push) begin
                sp <= sp + PW'(1);
            end else if (do_pop) begin
                sp <= sp - PW'(1);
            end
            if (push_ovf) begin
                ovf <= 1'b1;
            end
            if (pop_unf) begin
                unf <= 1'b1;
            end
        end
    end

    // Entries are not cleared; sp = 0 after reset hides any stale contents.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (do_push) begin
                mem[wr_idx] <= pc_in;
            end else if (do_replace) begin
                mem[top_idx] <= pc_in;
            end
        end
    end

endmodule
